nor4_exhaustive_checker: RTL and testbench

- Sequential driver and checker for the 4-input NOR standard cell; it forms the driving and observing end of the cell's A1..A4/ZN interface.
- Applies all 16 input combinations to a NOR4 instance, waits a programmable settle time, samples ZN, and compares it against the expected NOR.
- Reports pass/fail, a saturating mismatch count and (optionally) the first failing vector.
- Used in library silicon test structures and in cell-level regression benches.

---
 rtl/nor4_exhaustive_checker.sv | 220 ++++++++++++++++++++++
 tb/tb_nor4_exhaustive_checker.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nor4_exhaustive_checker.sv
// ---------------------------------------------------------------------------
// nor4_exhaustive_checker
//
// Purpose:
//   Drives all 16 input combinations into a 4-input NOR cell and checks its
//   output. Each vector is held for SETTLE_CYCLES cycles and then ZN is
//   sampled for one cycle. The whole 16-vector sweep is repeated PASSES
//   times. Mismatches are counted in a saturating counter.
//
// Optional feature (compile-time macro NOR4_CHK_FIRSTFAIL_EN):
//   When defined, the first failing vector of a run is captured on FAIL_VEC
//   and flagged by FAIL_VLD. When undefined, both ports are absent.
//
// Ports:
//   CLK       in   rising-edge clock
//   RST       in   synchronous active-high reset
//   START     in   one-cycle pulse, starts a run from IDLE or DONE
//   ZN        in   output of the cell under test
//   A1..A4    out  cell inputs, vector bits 0..3
//   BUSY      out  high while a run is in progress
//   DONE      out  high while results are being held
//   PASS      out  DONE with no mismatches recorded
//   ERR_CNT   out  saturating mismatch count (ERR_W bits)
//   FAIL_VEC  out  first failing {A4,A3,A2,A1} (optional)
//   FAIL_VLD  out  FAIL_VEC holds a captured vector (optional)
// ---------------------------------------------------------------------------
module nor4_exhaustive_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_W         = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ZN,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic             A4,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT
`ifdef NOR4_CHK_FIRSTFAIL_EN
  ,
  output logic [3:0]       FAIL_VEC,
  output logic             FAIL_VLD
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       PASS_LAST   = 8'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_e           state_q, state_d;
  logic [3:0]       vec_q, vec_d;
  logic [7:0]       passCnt_q, passCnt_d;
  logic [7:0]       settleCnt_q, settleCnt_d;
  logic [3:0]       aOut_q, aOut_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] errCnt_q, errCnt_d;
`ifdef NOR4_CHK_FIRSTFAIL_EN
  logic [3:0]       failVec_q, failVec_d;
  logic             failVld_q, failVld_d;
`endif

  logic startAccept;
  logic mismatch;

  // A run may only be (re)started from IDLE or once DONE is actually
  // showing; in the first DONE-state cycle BUSY is still high, so a START
  // there is treated as arriving while busy and is dropped.
  assign startAccept = START && ((state_q == S_IDLE) ||
                                 ((state_q == S_DONE) && done_q));

  // The vector currently on A1..A4 is vec_q whenever we are in SAMPLE, so
  // the expected cell output is simply the NOR of that vector.
  assign mismatch = (state_q == S_SAMPLE) && (ZN != ~(|vec_q));

  // State and output registers. Reset is synchronous and returns every
  // register, including partial results, to its idle value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      vec_q       <= 4'd0;
      passCnt_q   <= 8'd0;
      settleCnt_q <= 8'd0;
      aOut_q      <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      errCnt_q    <= '0;
`ifdef NOR4_CHK_FIRSTFAIL_EN
      failVec_q   <= 4'd0;
      failVld_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      passCnt_q   <= passCnt_d;
      settleCnt_q <= settleCnt_d;
      aOut_q      <= aOut_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      errCnt_q    <= errCnt_d;
`ifdef NOR4_CHK_FIRSTFAIL_EN
      failVec_q   <= failVec_d;
      failVld_q   <= failVld_d;
`endif
    end
  end

  // Next-state logic. A accepted START overrides whatever DONE/IDLE would
  // do and clears all run results. Otherwise SETTLE counts out the hold
  // time and SAMPLE scores the vector and steps to the next one.
  // The registered outputs are derived from the next state so that A1..A4
  // and BUSY change on the same edge as the state; DONE/PASS are taken from
  // the current DONE state, which places their rise one cycle after the
  // last sample.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    passCnt_d   = passCnt_q;
    settleCnt_d = settleCnt_q;
    busy_d      = busy_q;
    errCnt_d    = errCnt_q;
`ifdef NOR4_CHK_FIRSTFAIL_EN
    failVec_d   = failVec_q;
    failVld_d   = failVld_q;
`endif

    if (startAccept) begin
      state_d     = S_SETTLE;
      vec_d       = 4'd0;
      passCnt_d   = 8'd0;
      settleCnt_d = 8'd0;
      busy_d      = 1'b1;
      errCnt_d    = '0;
`ifdef NOR4_CHK_FIRSTFAIL_EN
      failVec_d   = 4'd0;
      failVld_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_d = 1'b0;
        end

        S_SETTLE: begin
          if (settleCnt_q == SETTLE_LAST) begin
            state_d = S_SAMPLE;
          end else begin
            settleCnt_d = settleCnt_q + 8'd1;
          end
        end

        S_SAMPLE: begin
          if (mismatch) begin
            if (errCnt_q != ERR_MAX) begin
              errCnt_d = errCnt_q + ERR_W'(1);
            end
`ifdef NOR4_CHK_FIRSTFAIL_EN
            if (!failVld_q) begin
              failVec_d = vec_q;
              failVld_d = 1'b1;
            end
`endif
          end
          settleCnt_d = 8'd0;
          if ((vec_q == 4'hF) && (passCnt_q == PASS_LAST)) begin
            state_d = S_DONE;
          end else if (vec_q == 4'hF) begin
            vec_d     = 4'd0;
            passCnt_d = passCnt_q + 8'd1;
            state_d   = S_SETTLE;
          end else begin
            vec_d   = vec_q + 4'd1;
            state_d = S_SETTLE;
          end
        end

        S_DONE: begin
          busy_d = 1'b0;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    aOut_d = ((state_d == S_SETTLE) || (state_d == S_SAMPLE)) ? vec_d : 4'd0;
    done_d = (state_q == S_DONE) && !startAccept;
    pass_d = done_d && (errCnt_d == '0);
  end

  assign A1      = aOut_q[0];
  assign A2      = aOut_q[1];
  assign A3      = aOut_q[2];
  assign A4      = aOut_q[3];
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PASS    = pass_q;
  assign ERR_CNT = errCnt_q;
`ifdef NOR4_CHK_FIRSTFAIL_EN
  assign FAIL_VEC = failVec_q;
  assign FAIL_VLD = failVld_q;
`endif

endmodule

// File: tb/tb_nor4_exhaustive_checker.sv
// ---------------------------------------------------------------------------
// tb_nor4_exhaustive_checker
//
// Two checker instances share one clock: instance 0 runs a single sweep,
// instance 1 runs three sweeps so the error counter can saturate. Each
// instance drives a small cell model whose behaviour (ideal NOR, stuck-at-0,
// stuck-at-1, OR4) is chosen per run. A cycle-offset model predicts every
// output from the number of edges since the run started.
// Honours NOR4_CHK_FIRSTFAIL_EN for the optional first-fail outputs.
// ---------------------------------------------------------------------------
module tb_nor4_exhaustive_checker;

  localparam int SETTLE     = 2;
  localparam int PASSES_ONE = 1;
  localparam int PASSES_SAT = 3;
  localparam int ERR_WIDTH  = 5;

  localparam logic [1:0] MODE_NOR = 2'd0;
  localparam logic [1:0] MODE_SA0 = 2'd1;
  localparam logic [1:0] MODE_SA1 = 2'd2;
  localparam logic [1:0] MODE_OR4 = 2'd3;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [1:0]                rstW;
  logic [1:0]                startW;
  logic [1:0][1:0]           modeW;
  logic [1:0]                znW;
  logic [1:0][3:0]           aW;
  logic [1:0]                busyW;
  logic [1:0]                doneW;
  logic [1:0]                passW;
  logic [1:0][ERR_WIDTH-1:0] errW;
`ifdef NOR4_CHK_FIRSTFAIL_EN
  logic [1:0][3:0]           fvW;
  logic [1:0]                fvldW;
`endif

  int checks = 0;
  int errors = 0;

  // Behaviour of the cell under test for the selected fault mode.
  function automatic logic cellOut(input logic [1:0] mode, input logic [3:0] v);
    case (mode)
      MODE_NOR: return ~(|v);
      MODE_SA0: return 1'b0;
      MODE_SA1: return 1'b1;
      default:  return |v;
    endcase
  endfunction

  assign znW[0] = cellOut(modeW[0], aW[0]);
  assign znW[1] = cellOut(modeW[1], aW[1]);

  nor4_exhaustive_checker #(
    .SETTLE_CYCLES(SETTLE),
    .PASSES       (PASSES_ONE),
    .ERR_W        (ERR_WIDTH)
  ) dutOne (
    .CLK    (CLK),
    .RST    (rstW[0]),
    .START  (startW[0]),
    .ZN     (znW[0]),
    .A1     (aW[0][0]),
    .A2     (aW[0][1]),
    .A3     (aW[0][2]),
    .A4     (aW[0][3]),
    .BUSY   (busyW[0]),
    .DONE   (doneW[0]),
    .PASS   (passW[0]),
    .ERR_CNT(errW[0])
`ifdef NOR4_CHK_FIRSTFAIL_EN
    ,
    .FAIL_VEC(fvW[0]),
    .FAIL_VLD(fvldW[0])
`endif
  );

  nor4_exhaustive_checker #(
    .SETTLE_CYCLES(SETTLE),
    .PASSES       (PASSES_SAT),
    .ERR_W        (ERR_WIDTH)
  ) dutSat (
    .CLK    (CLK),
    .RST    (rstW[1]),
    .START  (startW[1]),
    .ZN     (znW[1]),
    .A1     (aW[1][0]),
    .A2     (aW[1][1]),
    .A3     (aW[1][2]),
    .A4     (aW[1][3]),
    .BUSY   (busyW[1]),
    .DONE   (doneW[1]),
    .PASS   (passW[1]),
    .ERR_CNT(errW[1])
`ifdef NOR4_CHK_FIRSTFAIL_EN
    ,
    .FAIL_VEC(fvW[1]),
    .FAIL_VLD(fvldW[1])
`endif
  );

  // -------------------------------------------------------------------------
  // Reference model: run state is just "running or not" plus the number of
  // clock edges since the accepted START edge. Everything else is derived
  // from that offset with plain arithmetic.
  // -------------------------------------------------------------------------
  logic       mValid = 1'b0;
  logic       mRun  [2];
  int         mK    [2];
  logic [1:0] mMode [2];

  function automatic int passesOf(input int w);
    return (w == 0) ? PASSES_ONE : PASSES_SAT;
  endfunction

  // Edge offset at which the last vector has been sampled.
  function automatic int runCycles(input int w);
    return 16 * passesOf(w) * (SETTLE + 1);
  endfunction

  function automatic int samplesTaken(input int w);
    int s;
    s = mK[w] / (SETTLE + 1);
    if (s > 16 * passesOf(w)) s = 16 * passesOf(w);
    return s;
  endfunction

  function automatic int mismatchCount(input int w);
    int         n;
    logic [3:0] v;
    n = 0;
    for (int j = 0; j < samplesTaken(w); j++) begin
      v = 4'(j % 16);
      if (cellOut(mMode[w], v) != ~(|v)) n++;
    end
    return n;
  endfunction

`ifdef NOR4_CHK_FIRSTFAIL_EN
  task automatic modelFirstFail(input int w, output logic [3:0] eFv, output logic eFvld);
    logic [3:0] v;
    eFv   = 4'd0;
    eFvld = 1'b0;
    if (mRun[w]) begin
      for (int j = 0; j < samplesTaken(w); j++) begin
        v = 4'(j % 16);
        if (!eFvld && (cellOut(mMode[w], v) != ~(|v))) begin
          eFv   = v;
          eFvld = 1'b1;
        end
      end
    end
  endtask
`endif

  task automatic modelOutputs(input int w, output logic [3:0] eA, output logic eBusy,
                              output logic eDone, output logic ePass,
                              output logic [ERR_WIDTH-1:0] eErr);
    int n;
    int k;
    int errs;
    eA    = 4'd0;
    eBusy = 1'b0;
    eDone = 1'b0;
    ePass = 1'b0;
    eErr  = '0;
    if (mRun[w]) begin
      n     = runCycles(w);
      k     = mK[w];
      eA    = (k < n) ? 4'((k / (SETTLE + 1)) % 16) : 4'd0;
      eBusy = (k <= n);
      eDone = (k > n);
      errs  = mismatchCount(w);
      eErr  = (errs > 31) ? 5'd31 : 5'(errs);
      ePass = eDone && (errs == 0);
    end
  endtask

  // Advance the model on each rising edge from the inputs applied before it.
  always @(posedge CLK) begin
    for (int w = 0; w < 2; w++) begin
      if (rstW[w]) begin
        mRun[w] <= 1'b0;
        mK[w]   <= 0;
        mValid  <= 1'b1;
      end else if (startW[w] && (!mRun[w] || (mK[w] > runCycles(w)))) begin
        mRun[w]  <= 1'b1;
        mK[w]    <= 0;
        mMode[w] <= modeW[w];
      end else if (mRun[w] && (mK[w] <= runCycles(w))) begin
        mK[w] <= mK[w] + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge CLK) begin
    logic [3:0]           eA;
    logic                 eBusy;
    logic                 eDone;
    logic                 ePass;
    logic [ERR_WIDTH-1:0] eErr;
`ifdef NOR4_CHK_FIRSTFAIL_EN
    logic [3:0]           eFv;
    logic                 eFvld;
`endif
    if (mValid) begin
      for (int w = 0; w < 2; w++) begin
        modelOutputs(w, eA, eBusy, eDone, ePass, eErr);
        checkOutput($sformatf("model_vec[%0d]", w),  32'(aW[w]),    32'(eA));
        checkOutput($sformatf("model_busy[%0d]", w), 32'(busyW[w]), 32'(eBusy));
        checkOutput($sformatf("model_done[%0d]", w), 32'(doneW[w]), 32'(eDone));
        checkOutput($sformatf("model_pass[%0d]", w), 32'(passW[w]), 32'(ePass));
        checkOutput($sformatf("model_err[%0d]", w),  32'(errW[w]),  32'(eErr));
`ifdef NOR4_CHK_FIRSTFAIL_EN
        modelFirstFail(w, eFv, eFvld);
        checkOutput($sformatf("model_fvec[%0d]", w), 32'(fvW[w]),   32'(eFv));
        checkOutput($sformatf("model_fvld[%0d]", w), 32'(fvldW[w]), 32'(eFvld));
`endif
      end
    end
  end

  // Apply one cycle of START/RST to one instance, starting on a falling edge
  // and returning on the falling edge after the edge that sampled it.
  task automatic applyStimulus(input int w, input logic startV, input logic rstV);
    startW[w] = startV;
    rstW[w]   = rstV;
    @(negedge CLK);
    startW[w] = 1'b0;
    rstW[w]   = 1'b0;
  endtask

  // Wait for DONE with a cycle budget; an expired budget is a failure.
  task automatic waitDone(input int w, input int limit, output int cyc);
    cyc = 0;
    while (!doneW[w] && (cyc < limit)) begin
      @(negedge CLK);
      cyc++;
    end
    if (!doneW[w]) checkOutput("done_timeout", 32'(doneW[w]), 32'd1);
  endtask

  initial begin
    int cyc;
    startW = 2'b00;
    rstW   = 2'b11;
    modeW  = '0;
    repeat (2) @(negedge CLK);
    rstW = 2'b00;

    $display("[TB] reset values");
    checkOutput("rst_vec",  32'(aW[0]),    32'd0);
    checkOutput("rst_busy", 32'(busyW[0]), 32'd0);
    checkOutput("rst_done", 32'(doneW[0]), 32'd0);
    checkOutput("rst_err",  32'(errW[0]),  32'd0);

    $display("[TB] ideal NOR, one pass");
    modeW[0] = MODE_NOR;
    applyStimulus(0, 1'b1, 1'b0);
    repeat (10) @(negedge CLK);
    checkOutput("vec_at_10", 32'(aW[0]), 32'h3);
    waitDone(0, 300, cyc);
    checkOutput("ideal_latency", 32'(cyc + 10), 32'd49);
    checkOutput("ideal_pass",    32'(passW[0]), 32'd1);
    checkOutput("ideal_err",     32'(errW[0]),  32'd0);

    $display("[TB] ZN stuck-at-0");
    modeW[0] = MODE_SA0;
    applyStimulus(0, 1'b1, 1'b0);
    waitDone(0, 300, cyc);
    checkOutput("sa0_latency", 32'(cyc), 32'd49);
    checkOutput("sa0_err",  32'(errW[0]),  32'd1);
    checkOutput("sa0_pass", 32'(passW[0]), 32'd0);
`ifdef NOR4_CHK_FIRSTFAIL_EN
    checkOutput("sa0_fvec", 32'(fvW[0]),   32'h0);
    checkOutput("sa0_fvld", 32'(fvldW[0]), 32'd1);
`endif

    $display("[TB] ZN stuck-at-1, three passes");
    modeW[1] = MODE_SA1;
    applyStimulus(1, 1'b1, 1'b0);
    waitDone(1, 600, cyc);
    checkOutput("sa1_latency", 32'(cyc), 32'd145);
    checkOutput("sa1_err",  32'(errW[1]),  32'd31);
    checkOutput("sa1_pass", 32'(passW[1]), 32'd0);
`ifdef NOR4_CHK_FIRSTFAIL_EN
    checkOutput("sa1_fvec", 32'(fvW[1]), 32'h1);
`endif

    $display("[TB] ZN as OR4");
    modeW[0] = MODE_OR4;
    applyStimulus(0, 1'b1, 1'b0);
    waitDone(0, 300, cyc);
    checkOutput("or4_err", 32'(errW[0]), 32'd16);
`ifdef NOR4_CHK_FIRSTFAIL_EN
    checkOutput("or4_fvec", 32'(fvW[0]), 32'h0);
`endif

    $display("[TB] restart from DONE with good cell");
    modeW[0] = MODE_NOR;
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("restart_err_clr",  32'(errW[0]),  32'd0);
    checkOutput("restart_done_clr", 32'(doneW[0]), 32'd0);
    waitDone(0, 300, cyc);
    checkOutput("restart_pass", 32'(passW[0]), 32'd1);
`ifdef NOR4_CHK_FIRSTFAIL_EN
    checkOutput("restart_fvld", 32'(fvldW[0]), 32'd0);
`endif

    $display("[TB] START while busy, then reset mid-run");
    applyStimulus(0, 1'b1, 1'b0);
    repeat (9) @(negedge CLK);
    applyStimulus(0, 1'b1, 1'b0);
    repeat (8) @(negedge CLK);
    applyStimulus(0, 1'b0, 1'b1);
    checkOutput("midrst_vec",  32'(aW[0]),    32'd0);
    checkOutput("midrst_busy", 32'(busyW[0]), 32'd0);
    checkOutput("midrst_done", 32'(doneW[0]), 32'd0);
    checkOutput("midrst_pass", 32'(passW[0]), 32'd0);
    checkOutput("midrst_err",  32'(errW[0]),  32'd0);
    applyStimulus(0, 1'b1, 1'b0);
    waitDone(0, 300, cyc);
    checkOutput("postrst_latency", 32'(cyc), 32'd49);
    checkOutput("postrst_pass", 32'(passW[0]), 32'd1);

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
